// File: rtl/preprocessor.sv
// Execute-stage operand preprocessor: decodes the control word, selects and
// extends ALU/shifter/store operands and registers them with unit enables.
module preprocessor (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable_ex,
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   input  logic [31:0] imm,
   input  logic [31:0] mem_data_read_in,
   input  logic [6:0]  control_in,
   output logic        mem_data_wr_en,
   output logic [31:0] mem_data_write_out,
   output logic [31:0] aluin1,
   output logic [31:0] aluin2,
   output logic [2:0]  operation_out,
   output logic [2:0]  opselect_out,
   output logic [4:0]  shift_number,
   output logic        enable_arith,
   output logic        enable_shift
);

   localparam logic [2:0] SHIFT_REG   = 3'b000;
   localparam logic [2:0] ARITH_LOGIC = 3'b001;
   localparam logic [2:0] MEM_WRITE   = 3'b100;
   localparam logic [2:0] MEM_READ    = 3'b101;

   localparam logic [2:0] LOADBYTE  = 3'b000;
   localparam logic [2:0] LOADBYTEU = 3'b100;
   localparam logic [2:0] LOADHALF  = 3'b001;
   localparam logic [2:0] LOADHALFU = 3'b101;

   localparam logic [2:0] OP_ADD = 3'b000;

   logic [2:0]  operation;
   logic        immp_regn;
   logic [2:0]  opselect;
   logic [31:0] immext;
   logic [31:0] load_val;

   logic        wr_en_d;
   logic [31:0] wdata_d;
   logic [31:0] aluin1_d;
   logic [31:0] aluin2_d;
   logic [2:0]  op_d;
   logic [2:0]  opsel_d;
   logic [4:0]  shamt_d;
   logic        arith_d;
   logic        shift_d;

   assign {operation, immp_regn, opselect} = control_in;
   assign immext = {{16{imm[15]}}, imm[15:0]};

   always_comb begin
      load_val = mem_data_read_in;
      case (operation)
         LOADBYTE:
            load_val = {{24{mem_data_read_in[7]}}, mem_data_read_in[7:0]};
         LOADBYTEU:
            load_val = {24'd0, mem_data_read_in[7:0]};
         LOADHALF:
            load_val = {{16{mem_data_read_in[15]}}, mem_data_read_in[15:0]};
         LOADHALFU:
            load_val = {16'd0, mem_data_read_in[15:0]};
         default:
            load_val = mem_data_read_in;
      endcase
   end

   // Data registers hold unless the active class names them.
   always_comb begin
      wr_en_d  = 1'b0;
      arith_d  = 1'b0;
      shift_d  = 1'b0;
      wdata_d  = mem_data_write_out;
      aluin1_d = aluin1;
      aluin2_d = aluin2;
      op_d     = operation_out;
      opsel_d  = opselect_out;
      shamt_d  = shift_number;
      if (enable_ex) begin
         opsel_d = opselect;
         unique case (1'b1)
            (opselect == ARITH_LOGIC): begin
               aluin1_d = src1;
               aluin2_d = immp_regn ? immext : src2;
               op_d     = operation;
               arith_d  = 1'b1;
            end
            (opselect == SHIFT_REG): begin
               aluin1_d = src1;
               aluin2_d = src2;
               shamt_d  = immp_regn ? imm[4:0] : src2[4:0];
               op_d     = operation;
               shift_d  = 1'b1;
            end
            (opselect == MEM_READ): begin
               aluin1_d = load_val;
               aluin2_d = 32'd0;
               op_d     = OP_ADD;
               arith_d  = 1'b1;
            end
            (opselect == MEM_WRITE): begin
               wdata_d  = src2;
               aluin1_d = src1;
               aluin2_d = immext;
               op_d     = OP_ADD;
               wr_en_d  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_data_wr_en     <= 1'b0;
         mem_data_write_out <= 32'd0;
         aluin1             <= 32'd0;
         aluin2             <= 32'd0;
         operation_out      <= 3'd0;
         opselect_out       <= 3'd0;
         shift_number       <= 5'd0;
         enable_arith       <= 1'b0;
         enable_shift       <= 1'b0;
      end else begin
         mem_data_wr_en     <= wr_en_d;
         mem_data_write_out <= wdata_d;
         aluin1             <= aluin1_d;
         aluin2             <= aluin2_d;
         operation_out      <= op_d;
         opselect_out       <= opsel_d;
         shift_number       <= shamt_d;
         enable_arith       <= arith_d;
         enable_shift       <= shift_d;
      end
   end

endmodule

// File: tb/tb_preprocessor.sv
// Directed table-driven bench for the execute-stage operand preprocessor.
module tb_preprocessor;

   logic        clock;
   logic        reset;
   logic        enable_ex;
   logic [31:0] src1, src2, imm, mem_data_read_in;
   logic [6:0]  control_in;
   logic        mem_data_wr_en;
   logic [31:0] mem_data_write_out, aluin1, aluin2;
   logic [2:0]  operation_out, opselect_out;
   logic [4:0]  shift_number;
   logic        enable_arith, enable_shift;

   typedef struct packed {
      logic        we;
      logic [31:0] wd;
      logic [31:0] a1;
      logic [31:0] a2;
      logic [2:0]  op;
      logic [2:0]  os;
      logic [4:0]  sh;
      logic        ea;
      logic        es;
   } out_t;

   typedef struct {
      logic [6:0]  ctrl;
      logic [31:0] s1;
      logic [31:0] s2;
      logic [31:0] im;
      logic [31:0] md;
      out_t        exp;
   } vec_t;

   int pass_cnt = 0;
   int total_cnt = 0;

   vec_t vecs [12];

   preprocessor dut (
      .clock              (clock),
      .reset              (reset),
      .enable_ex          (enable_ex),
      .src1               (src1),
      .src2               (src2),
      .imm                (imm),
      .mem_data_read_in   (mem_data_read_in),
      .control_in         (control_in),
      .mem_data_wr_en     (mem_data_wr_en),
      .mem_data_write_out (mem_data_write_out),
      .aluin1             (aluin1),
      .aluin2             (aluin2),
      .operation_out      (operation_out),
      .opselect_out       (opselect_out),
      .shift_number       (shift_number),
      .enable_arith       (enable_arith),
      .enable_shift       (enable_shift)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic out_t actual();
      return '{mem_data_wr_en, mem_data_write_out, aluin1, aluin2,
               operation_out, opselect_out, shift_number,
               enable_arith, enable_shift};
   endfunction

   task automatic check(input string name, input out_t exp);
      out_t act;
      act = actual();
      total_cnt++;
      if (act === exp) pass_cnt++;
      else
         $display("FAIL %s: got we=%b wd=%h a1=%h a2=%h op=%0d os=%0d sh=%0d ea=%b es=%b, want we=%b wd=%h a1=%h a2=%h op=%0d os=%0d sh=%0d ea=%b es=%b",
                  name, act.we, act.wd, act.a1, act.a2, act.op, act.os,
                  act.sh, act.ea, act.es, exp.we, exp.wd, exp.a1, exp.a2,
                  exp.op, exp.os, exp.sh, exp.ea, exp.es);
   endtask

   task automatic drive(input logic en, input logic [6:0] c,
                        input logic [31:0] s1, input logic [31:0] s2,
                        input logic [31:0] im, input logic [31:0] md);
      enable_ex        = en;
      control_in       = c;
      src1             = s1;
      src2             = s2;
      imm              = im;
      mem_data_read_in = md;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   out_t zero;

   initial begin
      zero = '0;
      reset = 1'b0;
      drive(1'b0, 7'b010_1_001, 32'h1111_1111, 32'h2222_2222,
            32'h3333_3333, 32'h4444_4444);

      vecs[0]  = '{7'b010_1_001, 32'd5, 32'd7, 32'h0001_8000, 32'd0,
                   '{1'b0, 32'h0, 32'd5, 32'hFFFF_8000, 3'd2, 3'd1, 5'd0, 1'b1, 1'b0}};
      vecs[1]  = '{7'b011_0_000, 32'hFFFF_FFF0, 32'h23, 32'd0, 32'd0,
                   '{1'b0, 32'h0, 32'hFFFF_FFF0, 32'h23, 3'd3, 3'd0, 5'd3, 1'b0, 1'b1}};
      vecs[2]  = '{7'b000_0_101, 32'd1, 32'd2, 32'd0, 32'h1234_F08A,
                   '{1'b0, 32'h0, 32'hFFFF_FF8A, 32'h0, 3'd0, 3'd5, 5'd3, 1'b1, 1'b0}};
      vecs[3]  = '{7'b100_0_101, 32'd1, 32'd2, 32'd0, 32'h1234_F08A,
                   '{1'b0, 32'h0, 32'h0000_008A, 32'h0, 3'd0, 3'd5, 5'd3, 1'b1, 1'b0}};
      vecs[4]  = '{7'b001_0_101, 32'd1, 32'd2, 32'd0, 32'h1234_F08A,
                   '{1'b0, 32'h0, 32'hFFFF_F08A, 32'h0, 3'd0, 3'd5, 5'd3, 1'b1, 1'b0}};
      vecs[5]  = '{7'b101_0_101, 32'd1, 32'd2, 32'd0, 32'h1234_F08A,
                   '{1'b0, 32'h0, 32'h0000_F08A, 32'h0, 3'd0, 3'd5, 5'd3, 1'b1, 1'b0}};
      vecs[6]  = '{7'b011_0_101, 32'd1, 32'd2, 32'd0, 32'h1234_F08A,
                   '{1'b0, 32'h0, 32'h1234_F08A, 32'h0, 3'd0, 3'd5, 5'd3, 1'b1, 1'b0}};
      vecs[7]  = '{7'b000_0_100, 32'h64, 32'hDEAD_BEEF, 32'd8, 32'd0,
                   '{1'b1, 32'hDEAD_BEEF, 32'h64, 32'h8, 3'd0, 3'd4, 5'd3, 1'b0, 1'b0}};
      vecs[8]  = '{7'b111_1_010, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF, 32'h77,
                   '{1'b0, 32'hDEAD_BEEF, 32'h64, 32'h8, 3'd0, 3'd2, 5'd3, 1'b0, 1'b0}};
      vecs[9]  = '{7'b001_1_000, 32'h80, 32'h1F, 32'hFFFF_FFE5, 32'd0,
                   '{1'b0, 32'hDEAD_BEEF, 32'h80, 32'h1F, 3'd1, 3'd0, 5'd5, 1'b0, 1'b1}};
      vecs[10] = '{7'b110_0_001, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'hFFFF_8000, 32'd0,
                   '{1'b0, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 32'h00FF_00FF, 3'd6, 3'd1, 5'd5, 1'b1, 1'b0}};
      vecs[11] = '{7'b111_0_000, 32'd1, 32'hFFFF_FFE2, 32'd0, 32'd0,
                   '{1'b0, 32'hDEAD_BEEF, 32'd1, 32'hFFFF_FFE2, 3'd7, 3'd0, 5'd2, 1'b0, 1'b1}};

      // Asynchronous reset, observed before the first clock edge.
      #2 reset = 1'b1;
      #1 check("reset_async", zero);
      drive(1'b1, 7'b010_1_001, 32'd5, 32'd7, 32'h0001_8000, 32'd0);
      step();
      check("reset_hold_edge1", zero);
      step();
      check("reset_hold_edge2", zero);
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 12; i++) begin
         drive(1'b1, vecs[i].ctrl, vecs[i].s1, vecs[i].s2,
               vecs[i].im, vecs[i].md);
         step();
         check($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Reset mid-stream drops the store that was about to be sampled.
      drive(1'b1, 7'b000_0_100, 32'h10, 32'hCAFE_F00D, 32'd4, 32'd0);
      #2 reset = 1'b1;
      #1 check("reset_midstream", zero);
      step();
      check("reset_midstream_edge", zero);
      reset = 1'b0;

      drive(1'b1, 7'b000_1_001, 32'd3, 32'd9, 32'h10, 32'd0);
      step();
      check("arith_before_stall",
            '{1'b0, 32'h0, 32'd3, 32'h10, 3'd0, 3'd1, 5'd0, 1'b1, 1'b0});
      drive(1'b0, 7'b011_0_000, 32'hFFFF_0000, 32'h1234_5677, 32'd0, 32'd0);
      step();
      check("stall_holds",
            '{1'b0, 32'h0, 32'd3, 32'h10, 3'd0, 3'd1, 5'd0, 1'b0, 1'b0});

      // Control sweep: class decode drives exactly the expected enables.
      for (int c = 0; c < 128; c++) begin
         logic [6:0] cw;
         logic [2:0] os;
         logic [5:0] want, got;
         cw = 7'(c);
         os = cw[2:0];
         drive(1'b1, cw, $urandom, $urandom, $urandom, $urandom);
         step();
         want = {os, os == 3'b100, os == 3'b001 || os == 3'b101,
                 os == 3'b000};
         got  = {opselect_out, mem_data_wr_en, enable_arith, enable_shift};
         total_cnt++;
         if (got === want) pass_cnt++;
         else
            $display("FAIL sweep ctrl=%b: got os/we/ea/es=%b want %b",
                     cw, got, want);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
